multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 253 +++++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
`default_nettype none
//==============================================================================
// Module      : multicycle_control
// Description : Multicycle MIPS-style control FSM (FETCH/DECODE/EXEC/MEM/WB/TRAP)
// Revision    : 1.0 - initial release
//==============================================================================
module multicycle_control #(
    parameter int MEM_TIMEOUT = 15,
    parameter int BYTE_OPS    = 1
) (
    input  logic       clk_in,
    input  logic       reset_n_in,
    input  logic [5:0] opcode_in,
    input  logic [5:0] func_in,
    input  logic [4:0] code_in,
    input  logic       imem_ready_in,
    input  logic       mem_ready_in,
    output logic       pc_enable_out,
    output logic       ir_we_out,
    output logic       regfile_we_out,
    output logic       alu_mux_select_out,
    output logic [5:0] alu_func_out,
    output logic       data_mem_re_out,
    output logic       data_mem_we_out,
    output logic [1:0] data_mem_size_out,
    output logic       data_mem_mux_select_out,
    output logic       signed_out,
    output logic       branch_out,
    output logic       jump_out,
    output logic       link_out,
    output logic       trap_out,
    output logic [2:0] state_out
);

    localparam logic [2:0] c_st_fetch  = 3'd0;
    localparam logic [2:0] c_st_decode = 3'd1;
    localparam logic [2:0] c_st_exec   = 3'd2;
    localparam logic [2:0] c_st_mem    = 3'd3;
    localparam logic [2:0] c_st_wb     = 3'd4;
    localparam logic [2:0] c_st_trap   = 3'd5;

    localparam logic [5:0] c_op_rtype  = 6'b000000;
    localparam logic [5:0] c_op_regimm = 6'b000001;
    localparam logic [5:0] c_op_j      = 6'b000010;
    localparam logic [5:0] c_op_jal    = 6'b000011;
    localparam logic [5:0] c_op_beq    = 6'b000100;
    localparam logic [5:0] c_op_bne    = 6'b000101;
    localparam logic [5:0] c_op_blez   = 6'b000110;
    localparam logic [5:0] c_op_bgtz   = 6'b000111;
    localparam logic [5:0] c_op_addi   = 6'b001000;
    localparam logic [5:0] c_op_addiu  = 6'b001001;
    localparam logic [5:0] c_op_slti   = 6'b001010;
    localparam logic [5:0] c_op_sltiu  = 6'b001011;
    localparam logic [5:0] c_op_andi   = 6'b001100;
    localparam logic [5:0] c_op_ori    = 6'b001101;
    localparam logic [5:0] c_op_xori   = 6'b001110;
    localparam logic [5:0] c_op_lui    = 6'b001111;
    localparam logic [5:0] c_op_lb     = 6'b100000;
    localparam logic [5:0] c_op_lh     = 6'b100001;
    localparam logic [5:0] c_op_lw     = 6'b100011;
    localparam logic [5:0] c_op_lbu    = 6'b100100;
    localparam logic [5:0] c_op_lhu    = 6'b100101;
    localparam logic [5:0] c_op_sb     = 6'b101000;
    localparam logic [5:0] c_op_sh     = 6'b101001;
    localparam logic [5:0] c_op_sw     = 6'b101011;

    localparam logic [5:0] c_fn_jr      = 6'b001000;
    localparam logic [5:0] c_fn_jalr    = 6'b001001;
    localparam logic [5:0] c_fn_syscall = 6'b001100;
    localparam logic [5:0] c_fn_break   = 6'b001101;
    localparam logic [5:0] c_fn_add     = 6'b100000;

    localparam logic [4:0] c_rt_bltz = 5'b00000;
    localparam logic [4:0] c_rt_bgez = 5'b00001;

    localparam logic [7:0] c_mem_last = 8'(MEM_TIMEOUT - 1);

    logic [2:0] r_state;
    logic [2:0] w_state_nxt;
    logic [5:0] r_opcode;
    logic [5:0] r_func;
    logic [4:0] r_code;
    logic [7:0] r_mem_cnt;

    logic       w_is_rtype;
    logic       w_is_jr;
    logic       w_is_jalr;
    logic       w_is_load;
    logic       w_is_store;
    logic       w_is_branch;
    logic       w_is_jump;
    logic       w_is_link;
    logic       w_is_imm_alu;
    logic       w_exec_to_fetch;
    logic [5:0] w_exec_alu_func;

    logic       w_pc_enable;
    logic       w_ir_we;
    logic       w_regfile_we;
    logic       w_re;
    logic       w_we;

    function automatic logic f_legal(input logic [5:0] op, input logic [5:0] fn,
                                     input logic [4:0] code);
        logic ok;
        ok = 1'b0;
        case (op)
            c_op_rtype:  ok = (fn != c_fn_syscall) && (fn != c_fn_break);
            c_op_regimm: ok = (code == c_rt_bltz) || (code == c_rt_bgez);
            c_op_j, c_op_jal, c_op_beq, c_op_bne, c_op_blez, c_op_bgtz,
            c_op_addi, c_op_addiu, c_op_slti, c_op_sltiu,
            c_op_andi, c_op_ori, c_op_xori, c_op_lui,
            c_op_lw, c_op_sw:    ok = 1'b1;
            c_op_lb, c_op_lh, c_op_lbu, c_op_lhu,
            c_op_sb, c_op_sh:    ok = (BYTE_OPS != 0);
            default:             ok = 1'b0;
        endcase
        return ok;
    endfunction

    // Classification of the instruction latched in DECODE
    assign w_is_rtype      = (r_opcode == c_op_rtype);
    assign w_is_jr         = w_is_rtype && (r_func == c_fn_jr);
    assign w_is_jalr       = w_is_rtype && (r_func == c_fn_jalr);
    assign w_is_load       = r_opcode inside {c_op_lw, c_op_lb, c_op_lh, c_op_lbu, c_op_lhu};
    assign w_is_store      = r_opcode inside {c_op_sw, c_op_sb, c_op_sh};
    assign w_is_branch     = r_opcode inside {c_op_regimm, c_op_beq, c_op_bne, c_op_blez, c_op_bgtz};
    assign w_is_jump       = (r_opcode == c_op_j) || (r_opcode == c_op_jal) || w_is_jr || w_is_jalr;
    assign w_is_link       = (r_opcode == c_op_jal) || w_is_jalr;
    assign w_is_imm_alu    = r_opcode inside {c_op_addi, c_op_addiu, c_op_slti, c_op_sltiu,
                                              c_op_andi, c_op_ori, c_op_xori, c_op_lui};
    assign w_exec_to_fetch = w_is_branch || (r_opcode == c_op_j) || w_is_jr;

    always_comb begin
        w_exec_alu_func = c_fn_add;
        case (r_opcode)
            c_op_rtype:  w_exec_alu_func = r_func;
            c_op_regimm: w_exec_alu_func = (r_code == c_rt_bgez) ? 6'b111001 : 6'b111000;
            c_op_andi:   w_exec_alu_func = 6'b100100;
            c_op_ori:    w_exec_alu_func = 6'b100101;
            c_op_xori:   w_exec_alu_func = 6'b100110;
            c_op_slti:   w_exec_alu_func = 6'b101000;
            c_op_sltiu:  w_exec_alu_func = 6'b101001;
            c_op_beq:    w_exec_alu_func = 6'b111100;
            c_op_bne:    w_exec_alu_func = 6'b111101;
            c_op_blez:   w_exec_alu_func = 6'b111110;
            c_op_bgtz:   w_exec_alu_func = 6'b111111;
            default:     w_exec_alu_func = c_fn_add;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_st_fetch:  if (imem_ready_in) w_state_nxt = c_st_decode;
            c_st_decode: w_state_nxt = f_legal(opcode_in, func_in, code_in) ? c_st_exec : c_st_trap;
            c_st_exec: begin
                if (w_is_load || w_is_store)
                    w_state_nxt = c_st_mem;
                else if (w_exec_to_fetch)
                    w_state_nxt = c_st_fetch;
                else
                    w_state_nxt = c_st_wb;
            end
            c_st_mem: begin
                // A completion on the last allowed cycle takes priority over the timeout
                if (mem_ready_in)
                    w_state_nxt = w_is_load ? c_st_wb : c_st_fetch;
                else if (r_mem_cnt == c_mem_last)
                    w_state_nxt = c_st_trap;
            end
            c_st_wb:     w_state_nxt = c_st_fetch;
            c_st_trap:   w_state_nxt = c_st_trap;
            default:     w_state_nxt = c_st_trap;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            r_state   <= c_st_fetch;
            r_opcode  <= 6'b000000;
            r_func    <= 6'b000000;
            r_code    <= 5'b00000;
            r_mem_cnt <= 8'd0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == c_st_decode) begin
                r_opcode <= opcode_in;
                r_func   <= func_in;
                r_code   <= code_in;
            end
            if (r_state != c_st_mem)
                r_mem_cnt <= 8'd0;
            else if (!mem_ready_in)
                r_mem_cnt <= r_mem_cnt + 8'd1;
        end
    end

    always_comb begin
        w_pc_enable             = 1'b0;
        w_ir_we                 = 1'b0;
        w_regfile_we            = 1'b0;
        w_re                    = 1'b0;
        w_we                    = 1'b0;
        alu_mux_select_out      = 1'b0;
        alu_func_out            = c_fn_add;
        data_mem_size_out       = 2'b11;
        data_mem_mux_select_out = 1'b0;
        signed_out              = 1'b1;
        branch_out              = 1'b0;
        jump_out                = 1'b0;
        link_out                = 1'b0;
        trap_out                = 1'b0;
        case (r_state)
            c_st_fetch: w_ir_we = imem_ready_in;
            c_st_exec: begin
                alu_mux_select_out = w_is_imm_alu || w_is_load || w_is_store;
                alu_func_out       = w_exec_alu_func;
                branch_out         = w_is_branch;
                jump_out           = w_is_jump;
                w_pc_enable        = w_exec_to_fetch;
            end
            c_st_mem: begin
                w_re        = w_is_load;
                w_we        = w_is_store;
                w_pc_enable = w_is_store && mem_ready_in;
                signed_out  = !((r_opcode == c_op_lbu) || (r_opcode == c_op_lhu));
                if (r_opcode inside {c_op_lb, c_op_lbu, c_op_sb})
                    data_mem_size_out = 2'b00;
                else if (r_opcode inside {c_op_lh, c_op_lhu, c_op_sh})
                    data_mem_size_out = 2'b01;
            end
            c_st_wb: begin
                w_regfile_we            = 1'b1;
                w_pc_enable             = 1'b1;
                data_mem_mux_select_out = w_is_load;
                link_out                = w_is_link;
            end
            c_st_trap: trap_out = 1'b1;
            default: ;
        endcase
    end

    // Strobes are forced low while reset is held, independent of the clock
    assign pc_enable_out   = w_pc_enable  & reset_n_in;
    assign ir_we_out       = w_ir_we      & reset_n_in;
    assign regfile_we_out  = w_regfile_we & reset_n_in;
    assign data_mem_re_out = w_re         & reset_n_in;
    assign data_mem_we_out = w_we         & reset_n_in;
    assign state_out       = r_state;

endmodule
`default_nettype wire
